// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 / exception controller at the M stage: arbitrates interrupts, exceptions,
// eret and mtc0, owns SR/Cause/EPC/PrID and steers fetch redirection and pipeline flush.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID     = 32'h0000_7001,
  parameter logic [31:0] SR_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic [31:0] pc_m,
  input  logic        pc_valid_m,
  input  logic        bd_m,
  input  logic        exc_valid_m,
  input  logic [4:0]  exc_code_m,
  input  logic        eret_m,
  input  logic [5:0]  hw_int,
  output logic [1:0]  pc_exc_sel,
  output logic [31:0] epc,
  output logic        flush
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  typedef enum logic [1:0] {
    SEL_PC      = 2'b00,
    SEL_HANDLER = 2'b01,
    SEL_EPC     = 2'b10
  } exc_sel_e;

  // Architectural state, kept as the individual fields that are actually stored
  logic [5:0]  sr_im_q,     sr_im_d;
  logic        sr_exl_q,    sr_exl_d;
  logic        sr_ie_q,     sr_ie_d;
  logic        cause_bd_q,  cause_bd_d;
  logic [5:0]  cause_ip_q,  cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q,       epc_d;

  logic     int_req;
  logic     exc_req;
  logic     req;
  logic     take_eret;
  logic     mtc0_wr;
  exc_sel_e sel;

  // A bubble in M never takes a request, so there is always a valid PC to save in EPC.
  assign int_req   = sr_ie_q & ~sr_exl_q & (|(hw_int & sr_im_q)) & pc_valid_m;
  assign exc_req   = exc_valid_m & ~sr_exl_q & pc_valid_m;
  assign req       = (int_req | exc_req) & ~reset;
  assign take_eret = eret_m & ~req & ~reset;
  assign mtc0_wr   = we & ~req & ~eret_m;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sel = SEL_PC;
    if (req)            sel = SEL_HANDLER;
    else if (take_eret) sel = SEL_EPC;
  end

  assign pc_exc_sel = sel;
  assign flush      = req | take_eret;
  assign epc        = epc_q;

  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = hw_int;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (req) begin
      sr_exl_d    = 1'b1;
      cause_bd_d  = bd_m;
      cause_exc_d = int_req ? 5'd0 : exc_code_m;
      epc_d       = bd_m ? (pc_m - 32'd4) : pc_m;
    end else if (eret_m) begin
      sr_exl_d = 1'b0;
    end else if (mtc0_wr) begin
      unique case (addr)
        REG_SR: begin
          sr_im_d  = din[15:10];
          sr_exl_d = din[1];
          sr_ie_d  = din[0];
        end
        REG_EPC: epc_d = {din[31:2], 2'b00};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      sr_im_q     <= SR_RESET[15:10];
      sr_exl_q    <= SR_RESET[1];
      sr_ie_q     <= SR_RESET[0];
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    dout = 32'd0;
    unique case (addr)
      REG_SR:    dout = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
      REG_CAUSE: dout = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'b00};
      REG_EPC:   dout = epc_q;
      REG_PRID:  dout = PRID;
      default:   dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Randomized scoreboard bench for cp0_exc_ctrl: a word-level CP0 model predicts each cycle's
// outputs into a queue; a negedge monitor pops and compares against the DUT.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] PRID     = 32'h0000_7001;
  localparam logic [31:0] SR_RESET = 32'h0000_0000;
  localparam logic [31:0] SR_MASK  = 32'h0000_FC03;

  logic        clk = 1'b0;
  logic        reset, we, pc_valid_m, bd_m, exc_valid_m, eret_m, flush;
  logic [4:0]  addr, exc_code_m;
  logic [31:0] din, dout, pc_m, epc;
  logic [5:0]  hw_int;
  logic [1:0]  pc_exc_sel;

  cp0_exc_ctrl #(.PRID(PRID), .SR_RESET(SR_RESET)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .din(din), .dout(dout),
    .pc_m(pc_m), .pc_valid_m(pc_valid_m), .bd_m(bd_m), .exc_valid_m(exc_valid_m),
    .exc_code_m(exc_code_m), .eret_m(eret_m), .hw_int(hw_int),
    .pc_exc_sel(pc_exc_sel), .epc(epc), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic        flush;
    logic [31:0] epc;
    logic [31:0] dout;
    int          n;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;
  int   cyc    = 0;

  // Reference state held as whole architectural words
  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v, input int n);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, n, act, exp_v);
    end
  endtask

  // Apply one cycle of inputs, predict outputs, then advance the model past the edge.
  task automatic drive(input bit rst, input bit w, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] pc, input bit pv, input bit bd, input bit ev,
                       input logic [4:0] ec, input bit er, input logic [5:0] hw,
                       input bit use_const = 0, input logic [31:0] const_dout = 32'd0);
    exp_t e;
    bit   exl, ie, intr, exc;
    @(posedge clk);
    #1;
    reset = rst; we = w; addr = a; din = d; pc_m = pc; pc_valid_m = pv; bd_m = bd;
    exc_valid_m = ev; exc_code_m = ec; eret_m = er; hw_int = hw;
    exl  = m_sr[1];
    ie   = m_sr[0];
    intr = ie && !exl && ((hw & m_sr[15:10]) != 6'd0) && pv;
    exc  = ev && !exl && pv;
    e.n    = cyc++;
    e.epc  = m_epc;
    e.dout = use_const ? const_dout : m_read(a);
    if (rst)              begin e.sel = 2'd0; e.flush = 1'b0; end
    else if (intr || exc) begin e.sel = 2'd1; e.flush = 1'b1; end
    else if (er)          begin e.sel = 2'd2; e.flush = 1'b1; end
    else                  begin e.sel = 2'd0; e.flush = 1'b0; end
    sbq.push_back(e);
    if (rst) begin
      m_sr = SR_RESET & SR_MASK; m_cause = 32'd0; m_epc = 32'd0;
    end else begin
      if (intr || exc) begin
        m_sr    = m_sr | 32'd2;
        m_cause = {bd, m_cause[30:7], (intr ? 5'd0 : ec), 2'b00};
        m_epc   = bd ? pc - 32'd4 : pc;
      end else if (er) begin
        m_sr = m_sr & ~32'd2;
      end else if (w) begin
        if (a == 5'd12) m_sr = d & SR_MASK;
        if (a == 5'd14) m_epc = d & ~32'd3;
      end
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(hw) << 10);
    end
  endtask

  // Idle cycle with a bubble in M: reads addr and checks dout against a literal value.
  task automatic spot(input logic [4:0] a, input logic [31:0] v);
    drive(0, 0, a, 32'd0, 32'd0, 0, 0, 0, 5'd0, 0, 6'd0, 1, v);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("pc_exc_sel", 32'(pc_exc_sel), 32'(e.sel), e.n);
        check("flush", 32'(flush), 32'(e.flush), e.n);
        check("epc", epc, e.epc, e.n);
        check("dout", dout, e.dout, e.n);
      end else if (done) begin
        break;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: monitor did not drain, %0d entries left", sbq.size());
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [4:0] addrs [6];
    logic [31:0] r;
    addrs = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd31};
    reset = 1; we = 0; addr = 0; din = 0; pc_m = 0; pc_valid_m = 0; bd_m = 0;
    exc_valid_m = 0; exc_code_m = 0; eret_m = 0; hw_int = 0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    drive(1, 0, 5'd12, 0, 0, 0, 0, 0, 0, 0, 6'd0);
    drive(1, 0, 5'd12, 0, 0, 0, 0, 0, 0, 0, 6'd0);
    spot(5'd12, SR_RESET & SR_MASK);
    spot(5'd0, 32'd0);
    // Interrupt on IM0 with IE set
    drive(0, 1, 5'd12, 32'h0000_0401, 0, 0, 0, 0, 0, 0, 6'd0);
    drive(0, 0, 5'd14, 0, 32'h3010, 1, 0, 0, 0, 0, 6'b000001);
    spot(5'd13, 32'h0000_0400);
    spot(5'd14, 32'h0000_3010);
    spot(5'd12, 32'h0000_0403);
    // Exception in a delay slot, then a second one ignored while EXL=1
    drive(0, 0, 5'd14, 0, 0, 1, 0, 0, 0, 1, 6'd0);
    drive(0, 0, 5'd13, 0, 32'h3024, 1, 1, 1, 5'd12, 0, 6'd0);
    spot(5'd14, 32'h0000_3020);
    spot(5'd13, 32'h8000_0030);
    drive(0, 0, 5'd13, 0, 32'h5000, 1, 0, 1, 5'd4, 0, 6'd0);
    spot(5'd14, 32'h0000_3020);
    spot(5'd13, 32'h8000_0030);
    // eret back to EPC
    drive(0, 0, 5'd14, 0, 0, 1, 0, 0, 0, 1, 6'd0);
    spot(5'd12, 32'h0000_0401);
    // Interrupt beats exception, and a simultaneous mtc0 SR=0 is dropped
    drive(0, 1, 5'd12, 32'h0, 32'h4000, 1, 0, 1, 5'd10, 0, 6'b000001);
    spot(5'd13, 32'h0000_0400);
    spot(5'd12, 32'h0000_0403);
    drive(0, 1, 5'd12, 32'h0, 0, 1, 0, 0, 0, 1, 6'd0);
    spot(5'd12, 32'h0000_0401);
    // mtc0 EPC alignment, read-only Cause, PrID, bubble defers interrupt
    drive(0, 1, 5'd14, 32'h0000_3007, 0, 0, 0, 0, 0, 0, 6'd0);
    spot(5'd14, 32'h0000_3004);
    drive(0, 1, 5'd13, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 6'd0);
    spot(5'd13, 32'h0000_0000);
    spot(5'd15, 32'h0000_7001);
    drive(0, 0, 5'd12, 0, 32'h6000, 0, 0, 0, 0, 0, 6'b000001);
    spot(5'd12, 32'h0000_0401);
    // Reset in the middle of a handler
    drive(0, 0, 5'd12, 0, 32'h6000, 1, 0, 0, 0, 0, 6'b000001);
    drive(1, 1, 5'd14, 32'h1234_5678, 32'h7000, 1, 1, 1, 5'd5, 1, 6'b111111);
    spot(5'd12, SR_RESET & SR_MASK);
    spot(5'd14, 32'h0000_0000);
    spot(5'd13, 32'h0000_0000);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit rs, w, pv, bd, ev, er;
      logic [4:0] a, ec;
      logic [31:0] d, pc;
      logic [5:0] hw;
      rs = ($urandom_range(0, 99) == 0);
      w  = ($urandom_range(0, 3) == 0);
      a  = addrs[$urandom_range(0, 5)];
      r  = $urandom();
      d  = ($urandom_range(0, 1) == 0) ? (r & 32'h0000_FC03) : r;
      r  = $urandom();
      pc = ($urandom_range(0, 9) == 0) ? {29'd0, r[2:0]} : r;
      pv = ($urandom_range(0, 3) != 0);
      bd = ($urandom_range(0, 3) == 0);
      ev = ($urandom_range(0, 7) == 0);
      r  = $urandom();
      ec = r[4:0];
      er = ($urandom_range(0, 11) == 0);
      hw = ($urandom_range(0, 2) == 0) ? r[10:5] : 6'd0;
      drive(rs, w, a, d, pc, pv, bd, ev, ec, er, hw);
    end
    done = 1;
  end

endmodule
